regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
// - Shares the single register-file write port between NREQ writeback requesters
//   (e.g. ALU, load unit, multiply unit), granting one of them per clock.
// - Uses round-robin grant with a valid/ready handshake per requester.
// - Drives registered RegWrite/WriteRegister/WriteData into the 32x32 register file,
//   which captures them on the following negedge clk.
// PARAMETERS
// - NREQ   3   number of requesters, 2..8
// - AW     5   register address width (32 registers)
// - DW     32  write data width
// PORTS
// - clk          in   1        system clock; all state updates on posedge
// - reset        in   1        reset, asynchronous, active-high
// - stall        in   1        1 = no grant this cycle (all req_ready=0)
// - req_valid    in   NREQ     per-requester write request
// - req_addr     in   NREQ*AW  packed destination register; requester i at [i*AW +: AW]
// - req_data     in   NREQ*DW  packed write data; requester i at [i*DW +: DW]
// - req_ready    out  NREQ     one-hot grant; transfer when valid&ready on posedge
// - RegWrite     out  1        registered write enable to the register file
// - WriteRegister out AW       registered write address
// - WriteData    out  DW       registered write data
// - coll_cnt     out  16       saturating count of cycles with >1 req_valid and stall=0
// BEHAVIOUR
// - Reset (async) sets RegWrite=0, WriteRegister=0, WriteData=0, coll_cnt=0 and rr_ptr=0.
//   req_ready is combinational and is 0 while reset=1.
// - Grant:
//   - req_ready[i]=1 iff stall=0, req_valid[i]=1, and i is the first valid index
//     found searching upward from rr_ptr, wrapping modulo NREQ.
//   - At most one ready bit is ever set.
//   - req_ready depends combinationally only on req_valid, stall and rr_ptr, never on
//     req_addr or req_data.
// - Round-robin pointer:
//   - On a transfer by requester g, rr_ptr <= (g+1) mod NREQ.
//   - Otherwise rr_ptr holds.
//   - Wrap: g=NREQ-1 sets rr_ptr to 0.
// - Output stage (latency of 1 posedge from transfer to RegWrite):
//   - Transfer with addr!=0: RegWrite<=1, WriteRegister<=addr, WriteData<=data.
//   - Transfer with addr==0: the request is accepted (ready asserted) but RegWrite<=0,
//     because register 0 is hardwired to zero. WriteRegister and WriteData still load.
//   - No transfer: RegWrite<=0; WriteRegister and WriteData hold.
// - Same address from two requesters in one cycle: only the RR winner writes this
//   cycle; the loser writes on a later cycle, so the last writer wins.
// - Requesters hold valid, addr and data stable until ready. A requester that drops
//   valid before ready is simply not served; there is no error.
// - stall=1 blocks grants, freezes rr_ptr and forces RegWrite<=0 next cycle.
// - coll_cnt increments when stall=0 and popcount(req_valid)>1. It saturates at 16'hFFFF.
// - Reset mid-operation clears the output stage immediately. Any write registered but
//   not yet captured by the register file is lost; requesters must re-present.
// CONFIGURATION
// - WB_FWD_EN defined: adds the following ports.
//   - rf_rd_addr1/2  in   AW
//   - rf_rd_data1/2  in   DW  raw register-file read data
//   - fwd_data1/2    out  DW
//   fwd_dataN = (RegWrite && WriteRegister==rf_rd_addrN && rf_rd_addrN!=0)
//   ? WriteData : rf_rd_dataN. This is purely combinational and covers reads in the
//   half-cycle before the negedge write.
// - WB_FWD_EN undefined: these ports and the forwarding logic are absent; the arbiter
//   behaviour is otherwise identical.
// TESTING
// - Reset: assert reset mid-cycle with RegWrite=1.
//   -> RegWrite, WriteRegister, WriteData and coll_cnt go to 0 immediately.
//   -> First grant after release goes to requester 0.
// - Single requester: req1 valid, addr=3, data=32'd12.
//   -> req_ready=3'b010 in the same cycle.
//   -> Next cycle RegWrite=1, WriteRegister=3, WriteData=12.
// - Fairness: all 3 valid for 6 cycles.
//   -> Grants go 0,1,2,0,1,2; coll_cnt=6; RegWrite high on 6 consecutive cycles.
// - Register 0: req2 writes addr=0, data=32'hDEAD.
//   -> req_ready[2]=1; next cycle RegWrite=0.
// - Stall: all valid, stall=1 for 2 cycles.
//   -> req_ready=0, RegWrite=0, rr_ptr unchanged; coll_cnt unchanged.
//   -> After stall drops, the same requester wins.
// - WB_FWD_EN: RegWrite=1, WriteRegister=8, WriteData=165, rf_rd_addr1=8, rf_rd_data1=0.
//   -> fwd_data1=165.
//   -> With rf_rd_addr1=0, fwd_data1 equals rf_rd_data1.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
// Shares the single register-file write port between NREQ writeback
// requesters. Each cycle one requester is granted, chosen round-robin.
// The winning write is registered onto RegWrite/WriteRegister/WriteData,
// and the register file captures it on the following negedge.
//
// Handshake (valid/ready): a requester raises req_valid[i] and holds
// req_addr/req_data stable until it sees req_ready[i]. A transfer happens
// on a posedge where req_valid[i] && req_ready[i]. req_ready is
// combinational from req_valid, stall and the round-robin pointer only.
// It never depends on the request payload. A requester may drop valid
// before it is served; nothing is recorded in that case.
//
// Optional feature: define WB_FWD_EN to add a combinational bypass. It
// forwards the pending registered write to two read ports, covering reads
// made in the half-cycle before the register file captures the write.
module regfile_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic                 RegWrite,
  output logic [AW-1:0]        WriteRegister,
  output logic [DW-1:0]        WriteData,
  output logic [15:0]          coll_cnt
`ifdef WB_FWD_EN
  ,
  input  logic [AW-1:0]        rf_rd_addr1,
  input  logic [AW-1:0]        rf_rd_addr2,
  input  logic [DW-1:0]        rf_rd_data1,
  input  logic [DW-1:0]        rf_rd_data2,
  output logic [DW-1:0]        fwd_data1,
  output logic [DW-1:0]        fwd_data2
`endif
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  // Round-robin pointer: index where the next search for a winner starts.
  logic [PW-1:0] rr_ptr_q, rr_ptr_d;

  // Output stage and collision counter.
  logic          regwrite_q, regwrite_d;
  logic [AW-1:0] wreg_q, wreg_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [15:0]   coll_cnt_q, coll_cnt_d;

  // Arbitration intermediates.
  logic          gnt_found;
  logic [PW-1:0] gnt_idx;
  logic [PW:0]   cand;
  logic          xfer;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_data;
  logic [3:0]    valid_cnt;

  // Find the first valid requester at or above rr_ptr, wrapping modulo NREQ.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (PW+1)'(k);
      if (cand >= (PW+1)'(NREQ)) begin
        cand = cand - (PW+1)'(NREQ);
      end
      if (!gnt_found && req_valid[cand[PW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[PW-1:0];
      end
    end
  end

  // One-hot ready; held low during reset and while stalled.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = !reset && !stall && gnt_found && (gnt_idx == PW'(i));
    end
  end

  // Route the winning requester's payload to the output stage.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) begin
        sel_addr = req_addr[i*AW +: AW];
        sel_data = req_data[i*DW +: DW];
      end
    end
  end

  assign xfer = |req_ready;

  // Next pointer: one past the winner, wrapping to 0; held when nothing transfers.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (xfer) begin
      if (gnt_idx == PW'(NREQ - 1)) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = gnt_idx + PW'(1);
      end
    end
  end

  // Output stage next state. Register 0 is hardwired to zero, so a write to it
  // is accepted but never enabled. Address and data still load for visibility.
  always_comb begin
    regwrite_d = 1'b0;
    wreg_d     = wreg_q;
    wdata_d    = wdata_q;
    if (xfer) begin
      regwrite_d = (sel_addr != '0);
      wreg_d     = sel_addr;
      wdata_d    = sel_data;
    end
  end

  // Collision counter: cycles with more than one requester competing, saturating.
  always_comb begin
    valid_cnt  = '0;
    coll_cnt_d = coll_cnt_q;
    for (int i = 0; i < NREQ; i++) begin
      valid_cnt = valid_cnt + 4'(req_valid[i]);
    end
    if (!stall && (valid_cnt > 4'd1) && (coll_cnt_q != 16'hFFFF)) begin
      coll_cnt_d = coll_cnt_q + 16'd1;
    end
  end

  // State registers; reset drops any write not yet captured by the register file.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q   <= '0;
      regwrite_q <= 1'b0;
      wreg_q     <= '0;
      wdata_q    <= '0;
      coll_cnt_q <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      regwrite_q <= regwrite_d;
      wreg_q     <= wreg_d;
      wdata_q    <= wdata_d;
      coll_cnt_q <= coll_cnt_d;
    end
  end

  assign RegWrite      = regwrite_q;
  assign WriteRegister = wreg_q;
  assign WriteData     = wdata_q;
  assign coll_cnt      = coll_cnt_q;

`ifdef WB_FWD_EN
  // Bypass the pending write to readers that sample before the negedge capture.
  always_comb begin
    fwd_data1 = rf_rd_data1;
    fwd_data2 = rf_rd_data2;
    if (regwrite_q && (wreg_q == rf_rd_addr1) && (rf_rd_addr1 != '0)) begin
      fwd_data1 = wdata_q;
    end
    if (regwrite_q && (wreg_q == rf_rd_addr2) && (rf_rd_addr2 != '0)) begin
      fwd_data2 = wdata_q;
    end
  end
`endif

  // At most one grant is ever issued.
  a_ready_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(req_ready));

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter: directed scenarios plus a randomized run,
// checked against a round-robin reference model held in the bench.
module tb_regfile_wb_arbiter;

  localparam int NREQ = 3;
  localparam int AW   = 5;
  localparam int DW   = 32;

  logic                clk;
  logic                reset;
  logic                stall;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ*AW-1:0]  req_addr;
  logic [NREQ*DW-1:0]  req_data;
  logic [NREQ-1:0]     req_ready;
  logic                RegWrite;
  logic [AW-1:0]       WriteRegister;
  logic [DW-1:0]       WriteData;
  logic [15:0]         coll_cnt;
  logic [AW-1:0]       rf_rd_addr1, rf_rd_addr2;
  logic [DW-1:0]       rf_rd_data1, rf_rd_data2;
  logic [DW-1:0]       fwd_data1, fwd_data2;

  int n_cmp;
  int n_fail;

  // Reference model state.
  int            m_ptr;
  int            m_cnt;
  logic          m_rw;
  logic [AW-1:0] m_wreg;
  logic [DW-1:0] m_wdata;

  // Scoreboard of enabled writes expected on the output stage.
  logic [AW+DW-1:0] exp_q[$];

  regfile_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
`ifdef WB_FWD_EN
    .rf_rd_addr1   (rf_rd_addr1),
    .rf_rd_addr2   (rf_rd_addr2),
    .rf_rd_data1   (rf_rd_data1),
    .rf_rd_data2   (rf_rd_data2),
    .fwd_data1     (fwd_data1),
    .fwd_data2     (fwd_data2),
`endif
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .req_valid     (req_valid),
    .req_addr      (req_addr),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .coll_cnt      (coll_cnt)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  task automatic model_reset();
    m_ptr = 0; m_cnt = 0; m_rw = 1'b0; m_wreg = '0; m_wdata = '0;
    exp_q.delete();
  endtask

  // Winner: first valid index searching upward from the pointer, modulo NREQ.
  function automatic int model_grant();
    if (stall || reset) return -1;
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (m_ptr + k) % NREQ;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input int g);
    logic [NREQ-1:0] one;
    one = 1;
    if (g < 0) return '0;
    return one << g;
  endfunction

  task automatic model_update(input int g);
    logic [AW-1:0] a;
    if (!stall && ($countones(req_valid) > 1) && (m_cnt < 65535)) m_cnt++;
    if (g >= 0) begin
      a       = req_addr[g*AW +: AW];
      m_rw    = (a != 0);
      m_wreg  = a;
      m_wdata = req_data[g*DW +: DW];
      m_ptr   = (g + 1) % NREQ;
    end else begin
      m_rw = 1'b0;
    end
  endtask

  function automatic logic [DW-1:0] fwd_model(input logic [AW-1:0] a, input logic [DW-1:0] d);
    return (m_rw && (m_wreg == a) && (a != 0)) ? m_wdata : d;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i]          = v;
    req_addr[i*AW +: AW]  = a;
    req_data[i*DW +: DW]  = d;
  endtask

  task automatic clear_reqs();
    req_valid = '0;
  endtask

  // Advance one clock; model follows the inputs present at the edge.
  task automatic tick(output int g);
    g = model_grant();
    @(posedge clk);
    model_update(g);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int g;
    n_cmp++; if (RegWrite !== 1'b0 || WriteRegister !== '0 || WriteData !== '0 || coll_cnt !== 16'd0) begin
      n_fail++; $display("FAIL reset_state: rw=%0b wr=%0d wd=%h cc=%0d required all 0", RegWrite, WriteRegister, WriteData, coll_cnt);
    end
    set_req(0, 1'b1, 5'd5, $urandom);
    set_req(1, 1'b1, 5'd7, $urandom);
    #1;
    n_cmp++; if (req_ready !== onehot(model_grant()) || req_ready !== 3'b001) begin
      n_fail++; $display("FAIL reset_pre_ready: got %b required %b", req_ready, onehot(model_grant()));
    end
    tick(g);
    n_cmp++; if (RegWrite !== m_rw || WriteRegister !== m_wreg || WriteData !== m_wdata || coll_cnt !== 16'(m_cnt)) begin
      n_fail++; $display("FAIL reset_pre_write: rw=%0b wr=%0d wd=%h cc=%0d required %0b %0d %h %0d",
                         RegWrite, WriteRegister, WriteData, coll_cnt, m_rw, m_wreg, m_wdata, m_cnt);
    end
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (RegWrite !== 1'b0 || WriteRegister !== '0 || WriteData !== '0 || coll_cnt !== 16'd0 || req_ready !== '0) begin
      n_fail++; $display("FAIL reset_async: rw=%0b wr=%0d wd=%h cc=%0d rdy=%b required all 0",
                         RegWrite, WriteRegister, WriteData, coll_cnt, req_ready);
    end
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 5'($urandom_range(1, 31)), $urandom);
    #1;
    n_cmp++; if (req_ready !== 3'b001) begin
      n_fail++; $display("FAIL reset_first_grant: got %b required 001", req_ready);
    end
  endtask

  task automatic test_fairness();
    int g;
    int seq[6] = '{0, 1, 2, 0, 1, 2};
    for (int k = 0; k < 6; k++) begin
      n_cmp++; if (req_ready !== onehot(seq[k]) || req_ready !== onehot(model_grant())) begin
        n_fail++; $display("FAIL fair_grant%0d: got %b required %b", k, req_ready, onehot(seq[k]));
      end
      tick(g);
      n_cmp++; if (RegWrite !== 1'b1 || WriteRegister !== m_wreg || WriteData !== m_wdata) begin
        n_fail++; $display("FAIL fair_write%0d: rw=%0b wr=%0d wd=%h required 1 %0d %h",
                           k, RegWrite, WriteRegister, WriteData, m_wreg, m_wdata);
      end
      if (g >= 0) set_req(g, 1'b1, 5'($urandom_range(1, 31)), $urandom);
    end
    n_cmp++; if (coll_cnt !== 16'd6 || coll_cnt !== 16'(m_cnt)) begin
      n_fail++; $display("FAIL fair_coll: got %0d required 6", coll_cnt);
    end
    clear_reqs();
  endtask

  task automatic test_single();
    int g;
    set_req(1, 1'b1, 5'd3, 32'd12);
    #1;
    n_cmp++; if (req_ready !== 3'b010) begin
      n_fail++; $display("FAIL single_ready: got %b required 010", req_ready);
    end
    tick(g);
    n_cmp++; if (RegWrite !== 1'b1 || WriteRegister !== 5'd3 || WriteData !== 32'd12) begin
      n_fail++; $display("FAIL single_write: rw=%0b wr=%0d wd=%0d required 1 3 12", RegWrite, WriteRegister, WriteData);
    end
    clear_reqs();
  endtask

  task automatic test_reg0();
    int g;
    set_req(2, 1'b1, 5'd0, 32'hDEAD);
    #1;
    n_cmp++; if (req_ready !== 3'b100 || req_ready !== onehot(model_grant())) begin
      n_fail++; $display("FAIL reg0_ready: got %b required 100", req_ready);
    end
    tick(g);
    n_cmp++; if (RegWrite !== 1'b0 || WriteRegister !== 5'd0 || WriteData !== 32'hDEAD) begin
      n_fail++; $display("FAIL reg0_write: rw=%0b wr=%0d wd=%h required 0 0 0000dead", RegWrite, WriteRegister, WriteData);
    end
    clear_reqs();
  endtask

  task automatic test_stall();
    int g;
    int cc_before;
    set_req(0, 1'b1, 5'd9, $urandom);
    #1;
    tick(g);
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 5'(i + 20), $urandom);
    stall = 1'b1;
    cc_before = m_cnt;
    for (int k = 0; k < 2; k++) begin
      #1;
      n_cmp++; if (req_ready !== '0) begin
        n_fail++; $display("FAIL stall_ready%0d: got %b required 000", k, req_ready);
      end
      tick(g);
      n_cmp++; if (RegWrite !== 1'b0 || WriteRegister !== m_wreg || WriteData !== m_wdata || coll_cnt !== 16'(cc_before)) begin
        n_fail++; $display("FAIL stall_out%0d: rw=%0b wr=%0d wd=%h cc=%0d required 0 %0d %h %0d",
                           k, RegWrite, WriteRegister, WriteData, coll_cnt, m_wreg, m_wdata, cc_before);
      end
    end
    stall = 1'b0;
    #1;
    n_cmp++; if (req_ready !== 3'b010) begin
      n_fail++; $display("FAIL stall_resume: got %b required 010", req_ready);
    end
    tick(g);
    n_cmp++; if (RegWrite !== 1'b1 || WriteRegister !== 5'd21) begin
      n_fail++; $display("FAIL stall_resume_write: rw=%0b wr=%0d required 1 21", RegWrite, WriteRegister);
    end
    clear_reqs();
  endtask

  task automatic test_random();
    int g;
    logic [AW+DW-1:0] exp;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i]) begin
          if ($urandom_range(0, 1) == 1) set_req(i, 1'b1, 5'($urandom_range(0, 31)), $urandom);
        end else if ($urandom_range(0, 15) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      stall = ($urandom_range(0, 7) == 0);
      #1;
      g = model_grant();
      n_cmp++; if (req_ready !== onehot(g)) begin
        n_fail++; $display("FAIL rand_ready c=%0d: got %b required %b", c, req_ready, onehot(g));
      end
      if (g >= 0 && req_addr[g*AW +: AW] != 0) exp_q.push_back({req_addr[g*AW +: AW], req_data[g*DW +: DW]});
      tick(g);
      n_cmp++; if (RegWrite !== m_rw || WriteRegister !== m_wreg || WriteData !== m_wdata || coll_cnt !== 16'(m_cnt)) begin
        n_fail++; $display("FAIL rand_out c=%0d: rw=%0b wr=%0d wd=%h cc=%0d required %0b %0d %h %0d",
                           c, RegWrite, WriteRegister, WriteData, coll_cnt, m_rw, m_wreg, m_wdata, m_cnt);
      end
      if (RegWrite === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL rand_sb c=%0d: got write %0d=%h required none", c, WriteRegister, WriteData);
        end else begin
          exp = exp_q.pop_front();
          if ({WriteRegister, WriteData} !== exp) begin
            n_fail++; $display("FAIL rand_sb c=%0d: got %0d=%h required %0d=%h",
                               c, WriteRegister, WriteData, exp[AW+DW-1:DW], exp[DW-1:0]);
          end
        end
      end
      if (g >= 0) req_valid[g] = 1'b0;
    end
    n_cmp++; if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL rand_sb_drain: got %0d pending required 0", exp_q.size());
    end
    stall = 1'b0;
    clear_reqs();
  endtask

`ifdef WB_FWD_EN
  task automatic test_fwd();
    int g;
    logic [DW-1:0] r;
    set_req(0, 1'b1, 5'd8, 32'd165);
    set_req(1, 1'b0, 5'd0, 32'd0);
    set_req(2, 1'b0, 5'd0, 32'd0);
    #1;
    tick(g);
    rf_rd_addr1 = 5'd8;  rf_rd_data1 = 32'd0;
    rf_rd_addr2 = 5'd13; rf_rd_data2 = $urandom;
    #1;
    n_cmp++; if (fwd_data1 !== 32'd165 || fwd_data1 !== fwd_model(rf_rd_addr1, rf_rd_data1)) begin
      n_fail++; $display("FAIL fwd_hit: got %0d required 165", fwd_data1);
    end
    n_cmp++; if (fwd_data2 !== fwd_model(rf_rd_addr2, rf_rd_data2)) begin
      n_fail++; $display("FAIL fwd_miss: got %h required %h", fwd_data2, fwd_model(rf_rd_addr2, rf_rd_data2));
    end
    r = $urandom;
    rf_rd_addr1 = 5'd0; rf_rd_data1 = r;
    #1;
    n_cmp++; if (fwd_data1 !== r) begin
      n_fail++; $display("FAIL fwd_reg0: got %h required %h", fwd_data1, r);
    end
    clear_reqs();
  endtask
`endif

  // Sequence of scenarios and final report.
  initial begin
    n_cmp = 0; n_fail = 0;
    reset = 1'b1; stall = 1'b0;
    req_valid = '0; req_addr = '0; req_data = '0;
    rf_rd_addr1 = '0; rf_rd_addr2 = '0; rf_rd_data1 = '0; rf_rd_data2 = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_fairness();
    test_single();
    test_reg0();
    test_stall();
    test_random();
`ifdef WB_FWD_EN
    test_fwd();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
